instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the instruction buffer depth; fixed at 2 in this revision.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-008 imem_rvalid  input  1  read data valid; arrives 1 or more cycles after acceptance.
REQ-009 imem_rdata  input  32  returned instruction word.
REQ-010 redirect  input  1  taken branch/jump; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored (treated as 00).
REQ-012 stall  input  1  decode cannot accept this cycle.
REQ-013 if_valid  output  1  if_instr/if_pc/opcode valid; consumed when if_valid && !stall.
REQ-014 if_instr  output  32  head instruction.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 opcode  output  6  if_instr[31:26], feeds decode control.

Function
REQ-017 States IDLE, REQ, WAIT; reset enters IDLE, IDLE SHALL go to REQ on the next clock.
REQ-018 REQ: imem_req=1, imem_addr=pc; issue only when buffer entries + outstanding < 2; on imem_ready, pc<=pc+4, capture pc as inflight_pc, go to WAIT.
REQ-019 WAIT: imem_req=0; on imem_rvalid, write {imem_rdata, inflight_pc} to buffer, go to REQ.
REQ-020 At most one outstanding request at any time.
REQ-021 Buffer SHALL be a 2-entry FIFO; head drives if_instr/if_pc/opcode; if_valid = (count != 0).
REQ-022 Simultaneous buffer write and consume SHALL leave count unchanged and preserve order.
REQ-023 Buffer SHALL never overflow; REQ-018 occupancy rule guarantees a slot for every return.
REQ-024 Minimum latency: request accepted cycle N, rvalid cycle N+1, if_valid cycle N+2.
REQ-025 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no error indication.
REQ-026 redirect SHALL have priority over all other events in its cycle: buffer flushed (count=0), pc<={redirect_pc[31:2],2'b00}, state->REQ.
REQ-027 redirect while a request is outstanding (including one accepted in the same cycle) SHALL set drop; the matching rvalid SHALL be discarded and clear drop.
REQ-028 While drop is set no new request SHALL issue.
REQ-029 redirect coincident with consume: consume is void; if_valid SHALL be 0 next cycle.
REQ-030 stall SHALL not affect an outstanding request; only issue is gated by occupancy.
REQ-031 imem_rvalid in IDLE or REQ with no outstanding request SHALL be ignored.

Reset
REQ-032 On rst_n low: pc=RESET_PC, state=IDLE, count=0, drop=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, opcode=0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; a late rvalid after release SHALL be ignored per REQ-031.

Structure
REQ-034 Shared package SHALL hold the state enum, RESET_PC default, and opcode constants (R-type 0, lw 35, sw 43, beq 4).
REQ-035 One sub-module, fetch_buf (2-entry FIFO with count), SHALL be instantiated; FSM and pc logic stay in instr_fetch.

Verification
REQ-036 Reset release, memory always ready, 1-cycle return, stall=0 -> if_pc sequence 0x0, 0x4, 0x8 with if_instr matching memory.
REQ-037 stall=1 for 5 cycles after first valid -> buffer fills to 2, imem_req=0, if_pc holds 0x0; release -> 0x4, 0x8 delivered in order, no loss.
REQ-038 redirect=1, redirect_pc=0x0000_0103 while request to 0x8 outstanding -> 0x8 data discarded; next if_pc=0x0000_0100.
REQ-039 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-040 rst_n pulsed low during WAIT, rvalid returned after release -> ignored; first if_pc=RESET_PC.
REQ-041 Memory returns opcode 35 word -> opcode=6'd35 same cycle if_valid rises.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states
//   opcode_t      : major opcodes decoded from instr[31:26]
//   fetch_entry_t : one instruction buffer entry {instr, pc}
package instr_fetch_pkg;

   localparam int unsigned XLEN              = 32;
   localparam int unsigned OPW               = 6;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned BUF_DEPTH_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   typedef enum logic [OPW-1:0] {
      OP_RTYPE = 6'd0,
      OP_BEQ   = 6'd4,
      OP_LW    = 6'd35,
      OP_SW    = 6'd43
   } opcode_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Major opcode field of an instruction word.
   function automatic logic [OPW-1:0] opcodeOf(input logic [XLEN-1:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO with occupancy count.
//   clk, rst_n : clock, async active-low reset
//   flush      : empty the buffer (dominates write/read)
//   wrEn/wrData: push one entry
//   rdEn       : pop the head entry
//   head       : current head entry
//   count      : number of valid entries (0..2)
module fetch_buf
   import instr_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         wrEn,
   input  fetch_entry_t wrData,
   input  logic         rdEn,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t mem [2];
   logic         wrPtr;
   logic         rdPtr;
   logic         doWr;
   logic         doRd;

   assign doWr = wrEn && !flush;
   assign doRd = rdEn && !flush && (count != 2'd0);
   assign head = mem[rdPtr];

   // Storage, pointers and count; push and pop in one cycle keep count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (doWr) begin
            mem[wrPtr] <= wrData;
            wrPtr      <= ~wrPtr;
         end
         if (doRd) rdPtr <= ~rdPtr;
         count <= count + 2'(doWr) - 2'(doRd);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// 2-entry instruction buffer, with redirect/flush and response dropping.
//   clk, rst_n                      : clock, async active-low reset
//   imem_req/imem_addr/imem_ready   : request handshake (registered req/addr)
//   imem_rvalid/imem_rdata          : read response
//   redirect/redirect_pc            : flush and refetch from new address
//   stall                           : decode cannot consume this cycle
//   if_valid/if_instr/if_pc/opcode  : buffer head toward decode
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned     BUF_DEPTH = BUF_DEPTH_DEFAULT
)(
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [OPW-1:0]  opcode
);

   localparam logic [1:0] FULL = 2'(BUF_DEPTH);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] inflightPc;
   logic            drop;

   fetch_entry_t    head;
   fetch_entry_t    wrEntry;
   logic [1:0]      count;

   logic            accept;
   logic            consume;
   logic            bufWr;
   logic [1:0]      cntNext;
   logic            dropOnRedirect;
   logic [XLEN-1:0] redirAddr;
   logic [XLEN-1:0] pcPlus4;

   assign accept    = imem_req && imem_ready;
   assign consume   = if_valid && !stall && !redirect;
   assign bufWr     = imem_rvalid && (state == WAIT) && !redirect;
   assign cntNext   = redirect ? 2'd0 : (count + 2'(bufWr) - 2'(consume));
   assign redirAddr = redirect_pc & ~32'h0000_0003;
   assign pcPlus4   = pc + 32'd4;
   assign wrEntry   = '{instr: imem_rdata, pc: inflightPc};

   // A request still owed a response after this cycle must be dropped:
   // accepted right now, or waiting with no response arriving this cycle.
   assign dropOnRedirect = accept || (((state == WAIT) || drop) && !imem_rvalid);

   fetch_buf u_fetch_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (redirect),
      .wrEn   (bufWr),
      .wrData (wrEntry),
      .rdEn   (consume),
      .head   (head),
      .count  (count)
   );

   assign if_valid = (count != 2'd0);
   assign if_instr = head.instr;
   assign if_pc    = head.pc;
   assign opcode   = opcodeOf(head.instr);

   // Fetch FSM; imem_req/imem_addr are registered from the next-cycle view
   // of state, drop and buffer occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         inflightPc <= '0;
         drop       <= 1'b0;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
      end else if (redirect) begin
         state     <= REQ;
         pc        <= redirAddr;
         imem_addr <= redirAddr;
         drop      <= dropOnRedirect;
         imem_req  <= !dropOnRedirect;
      end else begin
         unique case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= (cntNext < FULL);
            end
            REQ: begin
               if (accept) begin
                  pc         <= pcPlus4;
                  imem_addr  <= pcPlus4;
                  inflightPc <= pc;
                  state      <= WAIT;
                  imem_req   <= 1'b0;
               end else begin
                  if (drop && imem_rvalid) drop <= 1'b0;
                  imem_req <= !(drop && !imem_rvalid) && (cntNext < FULL);
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state    <= REQ;
                  imem_req <= (cntNext < FULL);
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a fixed-latency memory.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'h0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [5:0]  opcode;

   int checks = 0;
   int errors = 0;

   int          respLat  = 1;
   int          flushReq = 0;
   int          flushSeen = 0;
   int          pendCnt  = 0;
   logic [31:0] pendAddr = 32'h0;

   instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .opcode      (opcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: address 0x10 holds an lw word, others are addr^0x12340000.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h8C22_0010;
      return a ^ 32'h1234_0000;
   endfunction

   // Memory responder: accept seen in cycle N returns respLat cycles later.
   always @(negedge clk) begin
      imem_rvalid = 1'b0;
      if (flushSeen != flushReq) begin
         flushSeen = flushReq;
         pendCnt   = 0;
      end
      if (pendCnt > 0) begin
         pendCnt = pendCnt - 1;
         if (pendCnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(pendAddr);
         end
      end
      if (rst_n && imem_req && imem_ready) begin
         pendCnt  = respLat;
         pendAddr = imem_addr;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // Reset and release on a negedge; the next negedge is cycle n1.
   task automatic doReset(input int lat);
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      respLat     = lat;
      flushReq    = flushReq + 1;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic waitValid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (if_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
      tick(2);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
      checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL reset_opcode got %0d want 0", opcode); end
   endtask

   task automatic test_sequential;
      doReset(1);
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first_req got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
      tick();
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL seq_wait got req=%0b valid=%0b want 0/0", imem_req, if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL seq_latency got valid=%0b pc=%h want 1/0", if_valid, if_pc); end
      checks++; if (if_instr !== 32'h1234_0000 || opcode !== 6'd4) begin errors++; $display("FAIL seq_instr0 got %h op=%0d want 12340000/4", if_instr, opcode); end
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_gap got %0b want 0", if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h1234_0004) begin errors++; $display("FAIL seq_pc4 got v=%0b pc=%h i=%h want 1/4/12340004", if_valid, if_pc, if_instr); end
      tick(2);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h1234_0008) begin errors++; $display("FAIL seq_pc8 got v=%0b pc=%h i=%h want 1/8/12340008", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_stall;
      doReset(1);
      tick(3);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL stall_first got v=%0b pc=%h want 1/0", if_valid, if_pc); end
      stall = 1'b1;
      tick(4);
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL stall_full got req=%0b v=%0b pc=%h want 0/1/0", imem_req, if_valid, if_pc); end
      tick();
      stall = 1'b0;
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_rel4 got v=%0b pc=%h req=%0b want 1/4/1", if_valid, if_pc, imem_req); end
      checks++; if (if_instr !== 32'h1234_0004) begin errors++; $display("FAIL stall_instr4 got %h want 12340004", if_instr); end
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %0b want 0", if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h1234_0008) begin errors++; $display("FAIL stall_pc8 got v=%0b pc=%h i=%h want 1/8/12340008", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_back_to_back;
      doReset(1);
      tick(3);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL b2b_wr_rd got v=%0b pc=%h req=%0b want 1/4/1", if_valid, if_pc, imem_req); end
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", if_valid); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin errors++; $display("FAIL b2b_pc8 got v=%0b pc=%h want 1/8", if_valid, if_pc); end
   endtask

   task automatic test_redirect_outstanding;
      bit ok;
      doReset(2);
      tick(4);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL redir_pc0 got v=%0b pc=%h want 1/0", if_valid, if_pc); end
      tick(3);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL redir_pc4 got v=%0b pc=%h want 1/4", if_valid, if_pc); end
      tick();
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_inflight got req=%0b v=%0b want 0/0", imem_req, if_valid); end
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_drop got req=%0b v=%0b addr=%h want 0/0/100", imem_req, if_valid, imem_addr); end
      waitValid(12, ok);
      checks++; if (!ok || if_pc !== 32'h100 || if_instr !== 32'h1234_0100) begin errors++; $display("FAIL redir_target got ok=%0b pc=%h i=%h want 1/100/12340100", ok, if_pc, if_instr); end
   endtask

   task automatic test_redirect_consume;
      bit ok;
      doReset(1);
      tick(3);
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rc_flush got v=%0b req=%0b want 0/0", if_valid, imem_req); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rc_reissue got req=%0b addr=%h want 1/200", imem_req, imem_addr); end
      waitValid(10, ok);
      checks++; if (!ok || if_pc !== 32'h200) begin errors++; $display("FAIL rc_target got ok=%0b pc=%h want 1/200", ok, if_pc); end
   endtask

   task automatic test_wrap;
      doReset(1);
      tick();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b0) begin errors++; $display("FAIL wrap_align got addr=%h req=%0b want fffffffc/0", imem_addr, imem_req); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%0b addr=%h want 1/fffffffc", imem_req, imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL wrap_next got addr=%h req=%0b want 0/0", imem_addr, imem_req); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_deliver got v=%0b pc=%h addr=%h req=%0b want 1/fffffffc/0/1", if_valid, if_pc, imem_addr, imem_req); end
   endtask

   task automatic test_reset_midwait;
      bit ok;
      doReset(2);
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mw_req got %0b want 1", imem_req); end
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mw_wait got %0b want 0", imem_req); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mw_late_ignored got v=%0b req=%0b addr=%h want 0/1/0", if_valid, imem_req, imem_addr); end
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mw_no_ghost got %0b want 0", if_valid); end
      waitValid(10, ok);
      checks++; if (!ok || if_pc !== 32'h0 || if_instr !== 32'h1234_0000) begin errors++; $display("FAIL mw_first got ok=%0b pc=%h i=%h want 1/0/12340000", ok, if_pc, if_instr); end
   endtask

   task automatic test_opcode;
      bit found;
      logic prevValid;
      doReset(1);
      found = 1'b0;
      prevValid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         prevValid = if_valid;
         tick();
         if (if_valid && if_pc == 32'h10) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (!found || prevValid !== 1'b0) begin errors++; $display("FAIL op_rise got found=%0b prev=%0b want 1/0", found, prevValid); end
      checks++; if (opcode !== 6'd35 || if_instr !== 32'h8C22_0010) begin errors++; $display("FAIL op_lw got op=%0d i=%h want 35/8c220010", opcode, if_instr); end
   endtask

   initial begin
      imem_ready = 1'b1;
      test_reset();
      test_sequential();
      test_stall();
      test_back_to_back();
      test_redirect_outstanding();
      test_redirect_consume();
      test_wrap();
      test_reset_midwait();
      test_opcode();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
